// File: rtl/sram_arbiter2_if.sv
// Bundle of the two master req/done handshakes and the single-port SRAM bus.
// The arbiter takes the slave modport; the requesters and memory model take master.
interface sram_arbiter2_if #(
  parameter int AW = 8,
  parameter int DW = 8
) ();
  logic          m0_req;
  logic          m0_write;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_gnt;
  logic          m0_done;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_write;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_gnt;
  logic          m1_done;
  logic [DW-1:0] m1_rdata;

  logic [AW-1:0] saddr;
  logic [DW-1:0] sdatain;
  logic          swrite;
  logic [DW-1:0] srdataout;

  modport slave (
    input  m0_req, m0_write, m0_addr, m0_wdata,
    output m0_gnt, m0_done, m0_rdata,
    input  m1_req, m1_write, m1_addr, m1_wdata,
    output m1_gnt, m1_done, m1_rdata,
    output saddr, sdatain, swrite,
    input  srdataout
  );

  modport master (
    output m0_req, m0_write, m0_addr, m0_wdata,
    input  m0_gnt, m0_done, m0_rdata,
    output m1_req, m1_write, m1_addr, m1_wdata,
    input  m1_gnt, m1_done, m1_rdata,
    input  saddr, sdatain, swrite,
    output srdataout
  );
endinterface

// File: rtl/sram_arbiter2.sv
// Two-master round-robin arbiter/sequencer for a single-port SRAM with a
// fixed read latency; one transaction at a time, IDLE cycle between them.
module sram_arbiter2 #(
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input logic         clk,
  input logic         rst,
  sram_arbiter2_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  localparam logic [2:0] WAIT_LOAD = (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;

  state_t        state;
  logic          owner;
  logic          ptr;
  logic          cmd_write;
  logic [2:0]    cnt;
  logic          gnt0, gnt1;
  logic          done0, done1;
  logic          swrite_r;
  logic [AW-1:0] saddr_r;
  logic [DW-1:0] sdatain_r;
  logic [DW-1:0] rdata0, rdata1;

  logic          pick;
  logic          pick_write;
  logic [AW-1:0] pick_addr;
  logic [DW-1:0] pick_wdata;

  // ptr holds the last master served; on a tie the other one wins.
  always_comb begin
    pick = 1'b0;
    if (bus.m0_req && bus.m1_req) begin
      pick = ~ptr;
    end else begin
      pick = bus.m1_req;
    end
    pick_write = pick ? bus.m1_write : bus.m0_write;
    pick_addr  = pick ? bus.m1_addr  : bus.m0_addr;
    pick_wdata = pick ? bus.m1_wdata : bus.m0_wdata;
  end

  // saddr_r/sdatain_r double as the latched command, so later master changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      ptr       <= 1'b1;
      cmd_write <= 1'b0;
      cnt       <= 3'd0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      swrite_r  <= 1'b0;
      saddr_r   <= '0;
      sdatain_r <= '0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.m0_req || bus.m1_req) begin
            owner     <= pick;
            cmd_write <= pick_write;
            saddr_r   <= pick_addr;
            sdatain_r <= pick_wdata;
            swrite_r  <= pick_write;
            gnt0      <= ~pick;
            gnt1      <= pick;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          swrite_r <= 1'b0;
          if (cmd_write) begin
            done0 <= ~owner;
            done1 <= owner;
            state <= DONE;
          end else if (RD_LAT == 0) begin
            if (owner) rdata1 <= bus.srdataout;
            else       rdata0 <= bus.srdataout;
            done0 <= ~owner;
            done1 <= owner;
            state <= DONE;
          end else begin
            cnt   <= WAIT_LOAD;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 3'd0) begin
            if (owner) rdata1 <= bus.srdataout;
            else       rdata0 <= bus.srdataout;
            done0 <= ~owner;
            done1 <= owner;
            state <= DONE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        DONE: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          ptr   <= owner;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.m0_gnt   = gnt0;
  assign bus.m1_gnt   = gnt1;
  assign bus.m0_done  = done0;
  assign bus.m1_done  = done1;
  assign bus.m0_rdata = rdata0;
  assign bus.m1_rdata = rdata1;
  assign bus.saddr    = saddr_r;
  assign bus.sdatain  = sdatain_r;
  assign bus.swrite   = swrite_r;

endmodule

// File: tb/tb_sram_arbiter2.sv
// Scoreboard bench for sram_arbiter2: directed master transactions against a
// one-cycle-latency SRAM model, with a monitor checking done/rdata and slave writes.
module tb_sram_arbiter2;

  typedef struct {
    bit         master;
    bit         isRead;
    logic [7:0] rdata;
  } done_exp_t;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_exp_t;

  logic clk = 1'b0;
  logic rst;

  done_exp_t doneQ[$];
  wr_exp_t   writeQ[$];
  int        compared   = 0;
  int        mismatches = 0;
  int        gntCycles0 = 0;
  int        gntCycles1 = 0;

  logic [7:0] mem [256];

  sram_arbiter2_if #(.AW(8), .DW(8)) bus ();

  sram_arbiter2 #(.AW(8), .DW(8), .RD_LAT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Registered-read SRAM: data for the address seen at one edge appears after it.
  always @(posedge clk) begin
    if (bus.swrite) mem[bus.saddr] <= bus.sdatain;
    bus.srdataout <= mem[bus.saddr];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatches++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expectDone(input bit m, input bit isRead, input logic [7:0] rdata);
    done_exp_t e;
    e.master = m;
    e.isRead = isRead;
    e.rdata  = rdata;
    doneQ.push_back(e);
  endtask

  task automatic expectWrite(input logic [7:0] a, input logic [7:0] d);
    wr_exp_t e;
    e.addr = a;
    e.data = d;
    writeQ.push_back(e);
  endtask

  task automatic setCmd(input bit m, input bit req, input bit wr, input logic [7:0] a, input logic [7:0] d);
    if (m) begin
      bus.m1_req = req; bus.m1_write = wr; bus.m1_addr = a; bus.m1_wdata = d;
    end else begin
      bus.m0_req = req; bus.m0_write = wr; bus.m0_addr = a; bus.m0_wdata = d;
    end
  endtask

  task automatic dropReq(input bit m);
    if (m) bus.m1_req = 1'b0;
    else   bus.m0_req = 1'b0;
  endtask

  // Called at a negedge; returns the number of negedges until done is seen.
  task automatic driveMaster(input bit m, input bit wr, input logic [7:0] a, input logic [7:0] d, output int lat);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    setCmd(m, 1'b1, wr, a, d);
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      seen = m ? bus.m1_done : bus.m0_done;
    end
    dropReq(m);
    if (!seen) begin
      compared++;
      mismatches++;
      $display("[TB] FAIL done_timeout m%0d: got no done after %0d cycles, expected done", m, n);
    end
    lat = n;
  endtask

  task automatic applyStimulus(input string name, input bit m, input bit wr, input logic [7:0] a,
                               input logic [7:0] d, input int expLat, input logic [7:0] expRdata);
    int lat;
    if (wr) expectWrite(a, d);
    expectDone(m, !wr, expRdata);
    driveMaster(m, wr, a, d, lat);
    checkOutput(name, lat, expLat);
  endtask

  task automatic masterLoop(input bit m, input logic [7:0] abase, input logic [7:0] dbase);
    int lat;
    for (int i = 0; i < 4; i++) begin
      driveMaster(m, 1'b1, abase + 8'(2 * i), dbase + 8'(i), lat);
    end
  endtask

  task automatic runMonitor();
    done_exp_t e;
    wr_exp_t   w;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.m0_gnt) gntCycles0++;
        if (bus.m1_gnt) gntCycles1++;
        if (bus.m0_gnt || bus.m1_gnt) checkOutput("gnt_exclusive", {31'd0, bus.m0_gnt & bus.m1_gnt}, 32'd0);
        if (bus.swrite) begin
          if (writeQ.size() == 0) begin
            checkOutput("unexpected_swrite", {31'd0, bus.swrite}, 32'd0);
          end else begin
            w = writeQ.pop_front();
            checkOutput("swrite_saddr", bus.saddr, w.addr);
            checkOutput("swrite_sdatain", bus.sdatain, w.data);
          end
        end
        if (bus.m0_done || bus.m1_done) begin
          if (doneQ.size() == 0) begin
            checkOutput("unexpected_done", {30'd0, bus.m1_done, bus.m0_done}, 32'd0);
          end else begin
            e = doneQ.pop_front();
            checkOutput("done_master", {30'd0, bus.m1_done, bus.m0_done}, e.master ? 32'd2 : 32'd1);
            if (e.isRead) checkOutput("done_rdata", e.master ? bus.m1_rdata : bus.m0_rdata, e.rdata);
          end
        end
      end
    end
  endtask

  initial begin
    int l0, l1, g0s, g1s;
    rst = 1'b1;
    setCmd(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    setCmd(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    fork
      runMonitor();
    join_none
    repeat (2) @(negedge clk);

    checkOutput("rst_m0_gnt", bus.m0_gnt, 0);
    checkOutput("rst_m1_gnt", bus.m1_gnt, 0);
    checkOutput("rst_done", {bus.m1_done, bus.m0_done}, 0);
    checkOutput("rst_swrite", bus.swrite, 0);
    checkOutput("rst_saddr", bus.saddr, 0);
    checkOutput("rst_sdatain", bus.sdatain, 0);
    checkOutput("rst_m0_rdata", bus.m0_rdata, 0);
    checkOutput("rst_m1_rdata", bus.m1_rdata, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] single write");
    g0s = gntCycles0;
    g1s = gntCycles1;
    applyStimulus("write_latency", 1'b0, 1'b1, 8'h10, 8'hA5, 2, 8'h00);
    @(negedge clk);
    checkOutput("write_m0_gnt_cycles", gntCycles0 - g0s, 2);
    checkOutput("write_m1_gnt_cycles", gntCycles1 - g1s, 0);

    $display("[TB] read-back");
    applyStimulus("read_latency", 1'b1, 1'b0, 8'h10, 8'h00, 3, 8'hA5);
    @(negedge clk);

    $display("[TB] contention");
    expectWrite(8'h20, 8'h11); expectDone(1'b0, 1'b0, 8'h00);
    expectWrite(8'h21, 8'h22); expectDone(1'b1, 1'b0, 8'h00);
    fork
      driveMaster(1'b0, 1'b1, 8'h20, 8'h11, l0);
      driveMaster(1'b1, 1'b1, 8'h21, 8'h22, l1);
    join
    @(negedge clk);
    expectDone(1'b0, 1'b1, 8'h11);
    expectDone(1'b1, 1'b1, 8'h22);
    fork
      driveMaster(1'b0, 1'b0, 8'h20, 8'h00, l0);
      driveMaster(1'b1, 1'b0, 8'h21, 8'h00, l1);
    join
    @(negedge clk);

    $display("[TB] fairness");
    for (int i = 0; i < 4; i++) begin
      expectWrite(8'h40 + 8'(2 * i), 8'hA0 + 8'(i)); expectDone(1'b0, 1'b0, 8'h00);
      expectWrite(8'h41 + 8'(2 * i), 8'hB0 + 8'(i)); expectDone(1'b1, 1'b0, 8'h00);
    end
    fork
      masterLoop(1'b0, 8'h40, 8'hA0);
      masterLoop(1'b1, 8'h41, 8'hB0);
    join
    @(negedge clk);

    $display("[TB] command latch");
    applyStimulus("latch_wr30_latency", 1'b0, 1'b1, 8'h30, 8'h5C, 2, 8'h00);
    @(negedge clk);
    applyStimulus("latch_wr31_latency", 1'b0, 1'b1, 8'h31, 8'hC3, 2, 8'h00);
    @(negedge clk);
    checkOutput("write_keeps_rdata", bus.m0_rdata, 8'h11);
    expectDone(1'b0, 1'b1, 8'h5C);
    fork
      driveMaster(1'b0, 1'b0, 8'h30, 8'h00, l0);
      begin
        repeat (2) @(negedge clk);
        bus.m0_addr = 8'h31;
        @(negedge clk);
        checkOutput("latch_saddr", bus.saddr, 8'h30);
      end
    join
    checkOutput("latch_latency", l0, 3);
    @(negedge clk);

    $display("[TB] reset mid-read");
    setCmd(1'b1, 1'b1, 1'b0, 8'h21, 8'h00);
    @(negedge clk);
    checkOutput("pre_rst_m1_gnt", bus.m1_gnt, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_m1_gnt", bus.m1_gnt, 0);
    checkOutput("mid_rst_done", {bus.m1_done, bus.m0_done}, 0);
    checkOutput("mid_rst_swrite", bus.swrite, 0);
    checkOutput("mid_rst_saddr", bus.saddr, 0);
    dropReq(1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus("post_rst_read_latency", 1'b1, 1'b0, 8'h21, 8'h00, 3, 8'h22);
    repeat (3) @(negedge clk);

    checkOutput("done_queue_empty", doneQ.size(), 0);
    checkOutput("write_queue_empty", writeQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatches);
    $finish;
  end

endmodule
